// File: rtl/m_mux_pkg.sv
// Shared definitions for the m_mux_rr stream-gathering multiplexer.
// Holds the default geometry, the output FSM state type and the
// round-robin index increment used by the arbiter.
package m_mux_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_N     = 4;

    // Output stage: EMPTY means o_valid=0, FULL means a word is held on o_data
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Next search start after granting channel idx, wrapping at n
    function automatic int rr_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/m_rr_arbiter.sv
// Grant selection for m_mux_rr.
// Finds the first valid channel, searching upward from a start index and
// wrapping N-1 -> 0. With MUX_RR_EN defined the start index is a pointer
// that advances past each granted channel (round robin); with MUX_RR_EN
// undefined the search always starts at channel 0 (fixed priority) and
// no pointer register exists.
import m_mux_pkg::*;

module m_rr_arbiter #(
    parameter int N    = DEF_N,
    parameter int SELW = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_valid,
    input  logic            i_accept,
    output logic [N-1:0]    o_grant,
    output logic [SELW-1:0] o_idx
);

    logic [SELW-1:0] start;
    logic [SELW-1:0] cand;
    logic [SELW-1:0] idx;
    logic            found;

`ifdef MUX_RR_EN
    logic [SELW-1:0] ptr;

    assign start = ptr;

    // Advance the pointer to the channel after the one just granted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr <= '0;
        end else if (i_accept) begin
            ptr <= SELW'(rr_inc(int'(idx), N));
        end
    end
`else
    logic unused_ok;

    assign start     = '0;
    assign unused_ok = ^{i_clk, i_rst};
`endif

    // First valid channel at or after start; index arithmetic wraps in SELW bits
    always_comb begin
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = start + SELW'(k);
            if (!found && i_valid[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

    // One-hot grant only when the output stage actually takes the word
    always_comb begin
        o_grant = '0;
        if (i_accept) begin
            o_grant[idx] = 1'b1;
        end
    end

    assign o_idx = idx;

endmodule

// File: rtl/m_mux_rr.sv
// m_mux_rr: gathers WIDTH-bit words from N valid/ready sources onto one
// registered output stream tagged with the source index.
// Optional feature macro: MUX_RR_EN (round-robin arbitration; fixed
// priority from channel 0 when undefined).
//
// Handshake: a source word moves when i_valid[k] and o_ready[k] are both
// high on a rising edge; the output word moves when o_valid and i_ready
// are both high. o_ready is combinational from i_valid, i_ready and the
// output state; o_data/o_sel/o_valid are registered. o_valid is the
// registered image of the output FSM state (FULL <=> o_valid).
import m_mux_pkg::*;

module m_mux_rr #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = $clog2(N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]       i_valid,
    output logic [N-1:0]       o_ready,
    output logic [WIDTH-1:0]   o_data,
    output logic [SELW-1:0]    o_sel,
    output logic               o_valid,
    input  logic               i_ready
);

    state_t            state;
    logic              accept;
    logic [N-1:0]      grant;
    logic [SELW-1:0]   gidx;
    logic [WIDTH-1:0]  sel_word;

    // Take a new word when the output slot is free or being drained now;
    // nothing is granted while reset is asserted
    assign accept = !i_rst && (|i_valid) && (state == ST_EMPTY || i_ready);

    m_rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_accept (accept),
        .o_grant  (grant),
        .o_idx    (gidx)
    );

    assign o_ready = grant;

    // Data select for the granted channel, constant part-select bases only
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N; k++) begin
            if (gidx == SELW'(k)) begin
                sel_word = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output FSM with registered data, index and valid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_EMPTY;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state   <= ST_FULL;
                        o_valid <= 1'b1;
                        o_data  <= sel_word;
                        o_sel   <= gidx;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        // drain and refill in the same cycle: no bubble
                        o_data <= sel_word;
                        o_sel  <= gidx;
                    end else if (i_ready) begin
                        state   <= ST_EMPTY;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
